// File: rtl/prefix_adder_pkg.sv
// Shared definitions for the prefix adder family: the chunk width of the
// combinational prefix_adder and the state encoding of the sequential wrapper.
package prefix_adder_pkg;

   localparam int CHUNK_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/prefix_adder.sv
// Combinational 6-bit Kogge-Stone prefix adder: S = X + Y + c_in, S[6] is the
// carry-out. The carry-in is folded into the generate term of bit 0 so that
// every prefix group G[i:0] already includes it.
module prefix_adder (
   input  logic [5:0] X,
   input  logic [5:0] Y,
   input  logic       c_in,
   output logic [6:0] S
);

   logic [5:0] p0;
   logic [5:0] g0;
   logic [5:0] p1;
   logic [5:0] g1;
   logic [5:0] p2;
   logic [5:0] g2;
   logic [5:0] g3;
   logic [5:0] carry;

   // Three prefix levels (span 1, 2, 4), then sum bits from the group carries.
   always_comb begin
      p0    = X ^ Y;
      g0    = (X & Y) | {5'b0, p0[0] & c_in};
      g1    = g0 | (p0 & {g0[4:0], 1'b0});
      p1    = p0 & {p0[4:0], 1'b1};
      g2    = g1 | (p1 & {g1[3:0], 2'b00});
      p2    = p1 & {p1[3:0], 2'b11};
      g3    = g2 | (p2 & {g2[1:0], 4'b0000});
      carry = {g3[4:0], c_in};
      S     = {g3[5], p0 ^ carry};
   end

endmodule

// File: rtl/prefix_adder_seq.sv
// Multi-cycle wide adder: feeds one 6-bit chunk per cycle (LSB chunk first)
// through a single prefix_adder, carrying S[6] to the next chunk through a
// register. Operands arrive on a valid/ready input handshake; the full sum
// (with final carry-out as MSB) leaves on a valid/ready output handshake.
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; ready never depends combinationally on valid.
// Optional: define PREFIX_ADDER_SEQ_OVF_EN to add the signed overflow flag ovf.
import prefix_adder_pkg::*;

module prefix_adder_seq #(
   parameter int NUM_CHUNKS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0]  a,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0]  b,
   input  logic                           c_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CHUNK_W*NUM_CHUNKS:0]    sum,
   output logic                           busy
`ifdef PREFIX_ADDER_SEQ_OVF_EN
   ,
   output logic                           ovf
`endif
);

   localparam int W     = CHUNK_W * NUM_CHUNKS;
   localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   state_t             state;
   state_t             state_next;
   logic [W-1:0]       a_reg;
   logic [W-1:0]       b_reg;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx;
   logic [CHUNK_W-1:0] x_chunk;
   logic [CHUNK_W-1:0] y_chunk;
   logic [CHUNK_W:0]   s_chunk;
   logic               accept;
   logic               last_chunk;

   assign accept     = in_valid && (state == IDLE);
   assign last_chunk = (idx == LAST_IDX);

   // Chunk mux: select the current operand slices for the shared adder.
   always_comb begin
      x_chunk = a_reg[idx*CHUNK_W +: CHUNK_W];
      y_chunk = b_reg[idx*CHUNK_W +: CHUNK_W];
   end

   prefix_adder u_prefix_adder (
      .X    (x_chunk),
      .Y    (y_chunk),
      .c_in (carry_reg),
      .S    (s_chunk)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, leave RUN after the last chunk,
   // leave DONE once the consumer takes the sum.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)   state_next = RUN;
         RUN:     if (last_chunk) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == RUN);
   end

   // Datapath: latch operands on accept, write back one chunk per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         sum       <= '0;
      end else if (accept) begin
         a_reg     <= a;
         b_reg     <= b;
         carry_reg <= c_in;
         idx       <= '0;
         sum       <= '0;
      end else if (state == RUN) begin
         sum[idx*CHUNK_W +: CHUNK_W] <= s_chunk[CHUNK_W-1:0];
         carry_reg                   <= s_chunk[CHUNK_W];
         if (last_chunk) sum[W] <= s_chunk[CHUNK_W];
         else            idx    <= idx + 1'b1;
      end
   end

`ifdef PREFIX_ADDER_SEQ_OVF_EN
   // Signed overflow captured as the top chunk is written (entry to DONE);
   // the new sum MSB is bit CHUNK_W-1 of that chunk's adder output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (accept) begin
         ovf <= 1'b0;
      end else if ((state == RUN) && last_chunk) begin
         ovf <= (a_reg[W-1] == b_reg[W-1]) && (s_chunk[CHUNK_W-1] != a_reg[W-1]);
      end
   end
`endif

endmodule
